// File: rtl/ef_i2s_pcm_packer_if.sv
// rtl/ef_i2s_pcm_packer_if.sv - FIFO-drain and output-stream signals of the I2S PCM packer
interface ef_i2s_pcm_packer_if #(
  parameter int DW = 32
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/ef_i2s_pcm_packer.sv
// rtl/ef_i2s_pcm_packer.sv - drains I2S FIFO samples into pass-through or 2x16-bit packed words
// Optional build macro EF_I2S_PACKER_SAT_EN: saturate samples to 16 bits instead of truncating.
module ef_i2s_pcm_packer #(
  parameter int DW    = 32,
  parameter int CTR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  input  logic                pack_en,
  input  logic                swap,
  ef_i2s_pcm_packer_if.master bus,
  output logic                half_pend,
  output logic [CTR_W-1:0]    word_count
);

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rd;
  logic            ld_pass;
  logic            ld_half;
  logic            ld_pair;
  logic            accept;
  logic [15:0]     half;
  logic [15:0]     samp16;
  logic [DW-1:0]   data_q;

`ifdef EF_I2S_PACKER_SAT_EN
  logic pos_ovf;
  logic neg_ovf;

  // A signed 32-bit value fits in 16 bits only when bits 31..15 all match.
  assign pos_ovf = ~bus.fifo_rdata[DW-1] & (|bus.fifo_rdata[DW-2:15]);
  assign neg_ovf =  bus.fifo_rdata[DW-1] & ~(&bus.fifo_rdata[DW-2:15]);

  always_comb begin
    samp16 = bus.fifo_rdata[15:0];
    if (pos_ovf)
      samp16 = 16'h7FFF;
    else if (neg_ovf)
      samp16 = 16'h8000;
  end
`else
  assign samp16 = bus.fifo_rdata[15:0];
`endif

  assign rd = en & ~bus.fifo_empty & (state != S_OUT) & ~rst & ~flush;

  always_comb begin
    state_nxt = state;
    ld_pass   = 1'b0;
    ld_half   = 1'b0;
    ld_pair   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_LO: begin
        if (rd) begin
          if (pack_en) begin
            ld_half   = 1'b1;
            state_nxt = S_HI;
          end else begin
            ld_pass   = 1'b1;
            state_nxt = S_OUT;
          end
        end
      end
      // S_HI is only reachable in pack mode, so pack_en is deliberately ignored here.
      S_HI: begin
        if (rd) begin
          ld_pair   = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.m_ready) begin
          accept    = 1'b1;
          state_nxt = S_LO;
        end
      end
      default: state_nxt = S_LO;
    endcase
    if (flush) begin
      state_nxt = S_LO;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_LO;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      half       <= '0;
      half_pend  <= 1'b0;
      word_count <= '0;
    end else if (flush) begin
      half       <= '0;
      half_pend  <= 1'b0;
    end else begin
      if (ld_pass)
        data_q <= bus.fifo_rdata;
      if (ld_half) begin
        half      <= samp16;
        half_pend <= 1'b1;
      end
      if (ld_pair) begin
        data_q    <= swap ? {half, samp16} : {samp16, half};
        half_pend <= 1'b0;
      end
      if (accept)
        word_count <= word_count + 1'b1;
    end
  end

  assign bus.fifo_rd = rd;
  assign bus.m_valid = (state == S_OUT);
  assign bus.m_data  = data_q;

endmodule

// File: tb/tb_ef_i2s_pcm_packer.sv
// tb/tb_ef_i2s_pcm_packer.sv - directed table-driven bench for ef_i2s_pcm_packer
module tb_ef_i2s_pcm_packer;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          flush = 1'b0;
  logic          pack_en = 1'b0;
  logic          swap = 1'b0;
  logic          half_pend;
  logic [CW-1:0] word_count;

  logic [31:0]   mem [0:63];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  ef_i2s_pcm_packer_if #(.DW(32)) bus ();

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_rdata = mem[rd_ptr[5:0]];

  always @(posedge clk)
    if (bus.fifo_rd) rd_ptr <= rd_ptr + 1;

  ef_i2s_pcm_packer #(.DW(32), .CTR_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .pack_en    (pack_en),
    .swap       (swap),
    .bus        (bus),
    .half_pend  (half_pend),
    .word_count (word_count)
  );

  typedef struct {
    logic        pk;
    logic        sw;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] x);
    mem[wr_ptr[5:0]] = x;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic get_word(input string name, output logic [31:0] d);
    logic ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        d  = bus.m_data;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s timeout waiting for m_valid", name);
    end
  endtask

  task automatic wait_half(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (half_pend === 1'b1) ok = 1'b1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   d;
    logic          flag;
    logic [CW-1:0] cnt0;

    bus.m_ready = 1'b1;
    vt[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,          32'h0000_1234};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFE_0001};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0001_FFFE};
`ifdef EF_I2S_PACKER_SAT_EN
    vt[3] = '{1'b1, 1'b0, 32'h0001_0000, 32'hFFFE_0000, 32'h8000_7FFF};
    vt[5] = '{1'b1, 1'b0, 32'h0000_8000, 32'hFFFF_7FFF, 32'h8000_7FFF};
`else
    vt[3] = '{1'b1, 1'b0, 32'h0001_0000, 32'hFFFE_0000, 32'h0000_0000};
    vt[5] = '{1'b1, 1'b0, 32'h0000_8000, 32'hFFFF_7FFF, 32'h7FFF_8000};
`endif
    vt[4] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0,          32'hDEAD_BEEF};
    vt[6] = '{1'b1, 1'b1, 32'h0000_7FFF, 32'hFFFF_8000, 32'h7FFF_8000};

    // reset with a non-empty FIFO: no read may happen
    push(32'h0000_1234);
    repeat (3) @(negedge clk);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_data", bus.m_data, 32'd0);
    check("rst_half_pend", {31'd0, half_pend}, 32'd0);
    check("rst_word_count", {28'd0, word_count}, 32'd0);
    check("rst_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);

    // first read right after reset, valid exactly one cycle later
    rst = 1'b0;
    #1;
    check("t1_fifo_rd", {31'd0, bus.fifo_rd}, 32'd1);
    @(negedge clk);
    check("t1_fifo_rd_once", {31'd0, bus.fifo_rd}, 32'd0);
    check("t1_m_valid", {31'd0, bus.m_valid}, 32'd1);
    check("t1_m_data", bus.m_data, 32'h0000_1234);
    @(negedge clk);
    check("t1_m_valid_drop", {31'd0, bus.m_valid}, 32'd0);
    check("t1_word_count", {28'd0, word_count}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      pack_en = vt[i].pk;
      swap    = vt[i].sw;
      push(vt[i].s0);
      if (vt[i].pk) push(vt[i].s1);
      get_word($sformatf("vec%0d", i), d);
      check($sformatf("vec%0d_data", i), d, vt[i].exp);
    end
    @(negedge clk);
    check("vec_word_count", {28'd0, word_count}, 32'd8);

    // back-pressure: data held, no reads, no count
    pack_en = 1'b0;
    swap = 1'b0;
    bus.m_ready = 1'b0;
    push(32'h0000_00AA);
    push(32'h0000_00BB);
    get_word("stall_first", d);
    check("stall_data", d, 32'h0000_00AA);
    cnt0 = word_count;
    flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_data !== 32'h0000_00AA || bus.fifo_rd !== 1'b0 ||
          bus.m_valid !== 1'b1 || word_count !== cnt0)
        flag = 1'b0;
    end
    check("stall_hold", {31'd0, flag}, 32'd1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("stall_release_count", {28'd0, word_count}, 32'd9);
    get_word("stall_second", d);
    check("stall_second_data", d, 32'h0000_00BB);

    // flush discards a held half
    pack_en = 1'b1;
    push(32'h0000_0001);
    wait_half("flush_half_set");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_half_clr", {31'd0, half_pend}, 32'd0);
    check("flush_no_valid", {31'd0, bus.m_valid}, 32'd0);
    push(32'h0000_0002);
    push(32'h0000_0003);
    get_word("flush_pair", d);
    check("flush_pair_data", d, 32'h0003_0002);

    // flush in the accept cycle drops the word uncounted
    pack_en = 1'b0;
    push(32'h0000_0055);
    get_word("flush_drop", d);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_drop_valid", {31'd0, bus.m_valid}, 32'd0);
    check("flush_drop_count", {28'd0, word_count}, 32'd11);

    // en=0 blocks reads
    en = 1'b0;
    push(32'h0000_0066);
    flag = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.fifo_rd !== 1'b0 || bus.m_valid !== 1'b0) flag = 1'b0;
    end
    check("en_low_idle", {31'd0, flag}, 32'd1);
    en = 1'b1;
    get_word("en_resume", d);
    check("en_resume_data", d, 32'h0000_0066);
    @(negedge clk);
    check("en_resume_count", {28'd0, word_count}, 32'd12);

    // reset while a word is pending
    bus.m_ready = 1'b0;
    push(32'h0000_0077);
    get_word("rst_out", d);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_out_data", bus.m_data, 32'd0);
    check("rst_out_count", {28'd0, word_count}, 32'd0);
    bus.m_ready = 1'b1;

    // reset while a half is held: the half is lost
    pack_en = 1'b1;
    push(32'h0000_0009);
    wait_half("rst_hi_half_set");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_hi_half_clr", {31'd0, half_pend}, 32'd0);
    push(32'h0000_000A);
    push(32'h0000_000B);
    get_word("rst_hi_pair", d);
    check("rst_hi_pair_data", d, 32'h000B_000A);

    // counter wrap at 2^CW
    pack_en = 1'b0;
    for (int i = 0; i < 14; i++) begin
      push(32'h100 + i);
      get_word("wrap_fill", d);
    end
    @(negedge clk);
    check("wrap_max", {28'd0, word_count}, 32'd15);
    push(32'h0000_0200);
    get_word("wrap_last", d);
    check("wrap_last_data", d, 32'h0000_0200);
    @(negedge clk);
    check("wrap_zero", {28'd0, word_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
